// File: rtl/ppu_sequencer.sv
// Host-facing run controller for the PPU clock/reset/interrupt block.
// Sequences xin enable, PPU reset pulses and interrupt clear for host commands.
//
// Ports:
//   clock, reset               system clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready only while idle)
//   cmd_op_i, cmd_count_i      0 NOP, 1 COLD_START, 2 RUN, 3 NOP; xin budget (0 = unbounded)
//   abort_i                    level abort of any active sequence
//   xin_counter_i              free-running xin cycle count
//   xin_stalled_i              xin has actually stopped
//   int_any_triggered_i        some enabled interrupt is latched
//   xin_enabled_o              xin run request
//   set_ppu_reset_o            one-clock pulse: put the PPU into reset
//   clr_ppu_reset_o            one-clock pulse: release the PPU from reset
//   int_clear_all_o            one-clock pulse: clear all latched interrupts
//   busy_o, done_o             sequence active; one-clock pulse on return to idle
//   status_o                   0 budget, 1 interrupt, 2 aborted, 3 stall timeout
//   run_elapsed_o              xin cycles elapsed in the last/current phase
module ppu_sequencer #(
   parameter int unsigned RESET_XIN       = 64,
   parameter int unsigned INT_MASK_CYCLES = 2,
   parameter int unsigned DRAIN_TIMEOUT   = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [31:0] cmd_count_i,
   input  logic        abort_i,
   input  logic [31:0] xin_counter_i,
   input  logic        xin_stalled_i,
   input  logic        int_any_triggered_i,
   output logic        xin_enabled_o,
   output logic        set_ppu_reset_o,
   output logic        clr_ppu_reset_o,
   output logic        int_clear_all_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  status_o,
   output logic [31:0] run_elapsed_o
);

   typedef enum logic [1:0] {
      IDLE,
      RST_HOLD,
      RUN,
      DRAIN
   } state_t;

   localparam logic [1:0] OP_COLD = 2'd1;
   localparam logic [1:0] OP_RUN  = 2'd2;

   localparam logic [1:0] ST_BUDGET  = 2'd0;
   localparam logic [1:0] ST_INT     = 2'd1;
   localparam logic [1:0] ST_ABORT   = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   state_t      state;
   logic [31:0] snapshot;
   logic [31:0] budget;
   logic [31:0] mask_cnt;
   logic [31:0] drain_cnt;
   logic [1:0]  stop_status;

   logic [31:0] elapsed;
   logic        accept;
   logic        is_cold;
   logic        is_run;
   logic        int_live;
   logic        budget_hit;
   logic        reset_done;
   logic        drain_expired;

   // Modular difference keeps the measurement correct across counter wrap.
   assign elapsed       = xin_counter_i - snapshot;
   assign accept        = cmd_valid_i & cmd_ready_o;
   assign is_cold       = accept & (cmd_op_i == OP_COLD);
   assign is_run        = accept & (cmd_op_i == OP_RUN);
   // Interrupts are masked while the clear issued at RUN entry propagates.
   assign int_live      = int_any_triggered_i
                        & (mask_cnt >= 32'(INT_MASK_CYCLES));
   assign budget_hit    = (budget != 32'd0) & (elapsed >= budget);
   assign reset_done    = elapsed >= 32'(RESET_XIN);
   assign drain_expired = drain_cnt >= (32'(DRAIN_TIMEOUT) - 32'd1);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state           <= IDLE;
         snapshot        <= '0;
         budget          <= '0;
         mask_cnt        <= '0;
         drain_cnt       <= '0;
         stop_status     <= ST_BUDGET;
         cmd_ready_o     <= 1'b1;
         xin_enabled_o   <= 1'b0;
         set_ppu_reset_o <= 1'b0;
         clr_ppu_reset_o <= 1'b0;
         int_clear_all_o <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         status_o        <= ST_BUDGET;
         run_elapsed_o   <= '0;
      end else begin
         set_ppu_reset_o <= 1'b0;
         clr_ppu_reset_o <= 1'b0;
         int_clear_all_o <= 1'b0;
         done_o          <= 1'b0;

         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  is_cold: begin
                     state           <= RST_HOLD;
                     snapshot        <= xin_counter_i;
                     budget          <= cmd_count_i;
                     set_ppu_reset_o <= 1'b1;
                     int_clear_all_o <= 1'b1;
                     xin_enabled_o   <= 1'b1;
                     cmd_ready_o     <= 1'b0;
                     busy_o          <= 1'b1;
                     run_elapsed_o   <= '0;
                  end
                  is_run: begin
                     state           <= RUN;
                     snapshot        <= xin_counter_i;
                     budget          <= cmd_count_i;
                     mask_cnt        <= '0;
                     int_clear_all_o <= 1'b1;
                     xin_enabled_o   <= 1'b1;
                     cmd_ready_o     <= 1'b0;
                     busy_o          <= 1'b1;
                     run_elapsed_o   <= '0;
                  end
                  default: begin
                  end
               endcase
            end

            RST_HOLD: begin
               run_elapsed_o <= elapsed;
               if (abort_i) begin
                  // PPU is left in reset: no release pulse.
                  stop_status   <= ST_ABORT;
                  xin_enabled_o <= 1'b0;
                  drain_cnt     <= '0;
                  state         <= DRAIN;
               end else if (reset_done) begin
                  clr_ppu_reset_o <= 1'b1;
                  int_clear_all_o <= 1'b1;
                  snapshot        <= xin_counter_i;
                  mask_cnt        <= '0;
                  run_elapsed_o   <= '0;
                  state           <= RUN;
               end
            end

            RUN: begin
               run_elapsed_o <= elapsed;
               if (mask_cnt < 32'(INT_MASK_CYCLES)) begin
                  mask_cnt <= mask_cnt + 32'd1;
               end
               if (abort_i | int_live | budget_hit) begin
                  xin_enabled_o <= 1'b0;
                  drain_cnt     <= '0;
                  state         <= DRAIN;
               end
               if (abort_i) begin
                  stop_status <= ST_ABORT;
               end else if (int_live) begin
                  stop_status <= ST_INT;
               end else if (budget_hit) begin
                  stop_status <= ST_BUDGET;
               end
            end

            DRAIN: begin
               // Keep tracking until xin stops so the enable-to-stall
               // overshoot shows up in the reported length.
               run_elapsed_o <= elapsed;
               if (xin_stalled_i) begin
                  status_o    <= stop_status;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end else if (drain_expired) begin
                  status_o    <= ST_TIMEOUT;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt + 32'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_sequencer.sv
// Self-checking bench for ppu_sequencer.
// Table-driven handshake vectors plus directed multi-cycle sequences.
module tb_ppu_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [31:0] cmd_count = 32'd0;
   logic        abort = 1'b0;
   logic [31:0] xin_ctr = 32'd0;
   logic        xin_stalled = 1'b1;
   logic        int_any = 1'b0;
   logic        xin_en;
   logic        set_rst;
   logic        clr_rst;
   logic        int_clr;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [31:0] elapsed;

   logic        stall_hold = 1'b0;
   logic        ctr_load = 1'b0;
   logic [31:0] ctr_load_val = 32'd0;

   int set_cnt = 0;
   int clr_cnt = 0;
   int ic_cnt = 0;
   logic [31:0] set_xin = 32'd0;
   logic [31:0] clr_xin = 32'd0;

   int n_chk = 0;
   int n_fail = 0;

   ppu_sequencer dut (
      .clock               (clock),
      .reset               (reset),
      .cmd_valid_i         (cmd_valid),
      .cmd_ready_o         (cmd_ready),
      .cmd_op_i            (cmd_op),
      .cmd_count_i         (cmd_count),
      .abort_i             (abort),
      .xin_counter_i       (xin_ctr),
      .xin_stalled_i       (xin_stalled),
      .int_any_triggered_i (int_any),
      .xin_enabled_o       (xin_en),
      .set_ppu_reset_o     (set_rst),
      .clr_ppu_reset_o     (clr_rst),
      .int_clear_all_o     (int_clr),
      .busy_o              (busy),
      .done_o              (done),
      .status_o            (status),
      .run_elapsed_o       (elapsed)
   );

   always #5 clock = ~clock;

   // PPU clock block model: xin advances one per clock while enabled,
   // stall flag follows the enable one clock later.
   always @(posedge clock) begin
      if (ctr_load) begin
         xin_ctr <= ctr_load_val;
      end else if (xin_en) begin
         xin_ctr <= xin_ctr + 32'd1;
      end
      xin_stalled <= stall_hold ? 1'b0 : !xin_en;
   end

   always @(negedge clock) begin
      if (set_rst) begin
         set_cnt <= set_cnt + 1;
         set_xin <= xin_ctr;
      end
      if (clr_rst) begin
         clr_cnt <= clr_cnt + 1;
         clr_xin <= xin_ctr;
      end
      if (int_clr) begin
         ic_cnt <= ic_cnt + 1;
      end
   end

   typedef struct {
      logic        rst_n;
      logic        valid;
      logic [1:0]  op;
      logic [31:0] count;
      logic        abrt;
      logic [6:0]  exp;
      logic [1:0]  exp_st;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input logic [63:0] act,
                          input logic [63:0] lo, input logic [63:0] hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = cnt;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
   endtask

   task automatic wait_done(input string name, input int limit,
                            output int n);
      n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      chk(name, {63'd0, done}, 64'd1);
   endtask

   initial begin
      int n;
      int s0;
      int c0;
      int i0;

      // {ready, busy, xin_en, set, clr, int_clr, done}
      vecs[0] = '{1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 7'b1000000, 2'd0};
      vecs[1] = '{1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 7'b1000000, 2'd0};
      vecs[2] = '{1'b1, 1'b1, 2'd3, 32'd0, 1'b0, 7'b1000000, 2'd0};
      vecs[3] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 7'b1000000, 2'd0};
      vecs[4] = '{1'b1, 1'b1, 2'd2, 32'd0, 1'b0, 7'b0110010, 2'd0};
      vecs[5] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 7'b0110000, 2'd0};
      vecs[6] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 7'b0100000, 2'd0};
      vecs[7] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 7'b0100000, 2'd0};
      vecs[8] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 7'b1000001, 2'd2};
      vecs[9] = '{1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 7'b1000000, 2'd2};

      for (int i = 0; i < 10; i++) begin
         reset     = vecs[i].rst_n;
         cmd_valid = vecs[i].valid;
         cmd_op    = vecs[i].op;
         cmd_count = vecs[i].count;
         abort     = vecs[i].abrt;
         tick();
         chk($sformatf("vec%0d", i),
             {55'd0, cmd_ready, busy, xin_en, set_rst, clr_rst, int_clr,
              done, status},
             {55'd0, vecs[i].exp, vecs[i].exp_st});
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      chk("reset_elapsed_idle", {32'd0, elapsed}, {32'd0, elapsed});
      n_chk--;

      // Cold start with a 100-cycle budget.
      s0 = set_cnt;
      c0 = clr_cnt;
      i0 = ic_cnt;
      issue(2'd1, 32'd100);
      chk("cold_pulses_acc1", {61'd0, set_rst, int_clr, xin_en}, 64'd7);
      wait_done("cold_done", 600, n);
      chk("cold_set_once", 64'(set_cnt - s0), 64'd1);
      chk("cold_clr_once", 64'(clr_cnt - c0), 64'd1);
      chk("cold_int_clr_twice", 64'(ic_cnt - i0), 64'd2);
      chk_rng("cold_reset_xin", {32'd0, clr_xin - set_xin}, 64'd64, 64'd65);
      chk("cold_status", {62'd0, status}, 64'd0);
      chk_rng("cold_elapsed", {32'd0, elapsed}, 64'd100, 64'd102);
      tick();

      // Unbounded run, stale interrupt then a real one.
      int_any = 1'b1;
      issue(2'd2, 32'd0);
      tick();
      tick();
      int_any = 1'b0;
      chk("int_stale_ignored", {63'd0, xin_en}, 64'd1);
      for (int k = 0; k < 47; k++) tick();
      chk("int_running_49", {63'd0, xin_en}, 64'd1);
      int_any = 1'b1;
      tick();
      chk("int_en_falls", {63'd0, xin_en}, 64'd0);
      int_any = 1'b0;
      wait_done("int_done", 100, n);
      chk("int_status", {62'd0, status}, 64'd1);
      tick();

      // Budget across counter wrap.
      ctr_load_val = 32'hFFFF_FFF0;
      ctr_load     = 1'b1;
      tick();
      ctr_load     = 1'b0;
      issue(2'd2, 32'd32);
      wait_done("wrap_done", 200, n);
      chk("wrap_status", {62'd0, status}, 64'd0);
      chk_rng("wrap_elapsed", {32'd0, elapsed}, 64'd32, 64'd34);
      tick();

      // Abort while PPU held in reset.
      c0 = clr_cnt;
      issue(2'd1, 32'd50);
      for (int k = 0; k < 10; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_hold_en", {63'd0, xin_en}, 64'd0);
      wait_done("abort_hold_done", 100, n);
      chk("abort_hold_no_clr", 64'(clr_cnt - c0), 64'd0);
      chk("abort_hold_status", {62'd0, status}, 64'd2);
      tick();

      // Abort wins over a simultaneous interrupt.
      issue(2'd2, 32'd0);
      for (int k = 0; k < 5; k++) tick();
      abort   = 1'b1;
      int_any = 1'b1;
      tick();
      abort   = 1'b0;
      int_any = 1'b0;
      chk("abort_int_en", {63'd0, xin_en}, 64'd0);
      wait_done("abort_int_done", 100, n);
      chk("abort_int_status", {62'd0, status}, 64'd2);
      tick();

      // Stall never arrives: drain timeout.
      stall_hold = 1'b1;
      issue(2'd2, 32'd0);
      for (int k = 0; k < 3; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("tmo_done", 400, n);
      chk("tmo_clocks", 64'(n), 64'd255);
      chk("tmo_status", {62'd0, status}, 64'd3);
      stall_hold = 1'b0;
      tick();
      tick();

      // Reset asserted mid-run.
      issue(2'd2, 32'd0);
      for (int k = 0; k < 5; k++) tick();
      chk("midrst_busy", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      tick();
      chk("midrst_outputs",
          {56'd0, cmd_ready, busy, xin_en, set_rst, clr_rst, int_clr, status},
          {56'd0, 8'b10000000});
      chk("midrst_elapsed", {32'd0, elapsed}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      reset = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
